// File: rtl/cr16_pkg.sv
// Shared CR16 datapath definitions: default widths, reset PC, the link
// writeback sequencer encoding and the 8-bit sign-extension helper.
package cr16_pkg;

    localparam int          CR16_WIDTH    = 16;
    localparam logic [15:0] CR16_RESET_PC = 16'h0000;

    typedef enum logic {
        LINK_IDLE = 1'b0,
        LINK_PEND = 1'b1
    } link_state_t;

    function automatic logic [CR16_WIDTH-1:0] sext8(input logic [7:0] value);
        return {{(CR16_WIDTH-8){value[7]}}, value};
    endfunction

endpackage

// File: rtl/pc_mar_unit_if.sv
// Bus between the CR16 controller/register file and the PC/MAR stage.
// The master side drives the enables and operand values; the slave side
// (the PC/MAR unit) returns its registered PC, MAR, link value and counter.
interface pc_mar_unit_if #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
);

    logic                 PCEn;
    logic                 jumpEn;
    logic                 branchEn;
    logic                 JALEn;
    logic                 marRegEn;
    logic                 pcToMAREn;
    logic [7:0]           disp;
    logic [WIDTH-1:0]     jump_target;
    logic [WIDTH-1:0]     data_addr;
    logic [WIDTH-1:0]     pc;
    logic [WIDTH-1:0]     mar;
    logic [WIDTH-1:0]     link_addr;
    logic                 link_we;
    logic [CNT_WIDTH-1:0] pc_updates;

    modport master (
        output PCEn, jumpEn, branchEn, JALEn, marRegEn, pcToMAREn,
        output disp, jump_target, data_addr,
        input  pc, mar, link_addr, link_we, pc_updates
    );

    modport slave (
        input  PCEn, jumpEn, branchEn, JALEn, marRegEn, pcToMAREn,
        input  disp, jump_target, data_addr,
        output pc, mar, link_addr, link_we, pc_updates
    );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: jump beats branch beats increment.
// All sums wrap modulo 2^WIDTH; pc_plus1 is also the JAL return address.
module pc_next_calc
    import cr16_pkg::*;
#(
    parameter int WIDTH = CR16_WIDTH
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [7:0]       disp,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             jumpEn,
    input  logic             branchEn,
    output logic [WIDTH-1:0] pc_next,
    output logic [WIDTH-1:0] pc_plus1
);

    logic [WIDTH-1:0] dispExt;

    // Sign-extend through the shared helper, then resize with sign kept so
    // widths other than the default still get a correct displacement.
    assign dispExt  = WIDTH'($signed(sext8(disp)));
    assign pc_plus1 = pc + WIDTH'(1);

    // Priority mux for the next PC value.
    always_comb begin
        pc_next = pc_plus1;
        if (jumpEn) begin
            pc_next = jump_target;
        end else if (branchEn) begin
            pc_next = pc + dispExt;
        end
    end

endmodule

// File: rtl/pc_mar_unit.sv
// PC and memory-address register stage fed by the CR16 controller.
// Holds the PC, MAR, JAL link register, saturating PC-write counter and the
// two-phase sequencer that pulses link_we the cycle after a JAL update.
module pc_mar_unit
    import cr16_pkg::*;
#(
    parameter int               WIDTH     = CR16_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(CR16_RESET_PC),
    parameter int               CNT_WIDTH = 16
) (
    input logic          clk,
    input logic          reset,
    pc_mar_unit_if.slave bus
);

    logic [WIDTH-1:0]     pcReg;
    logic [WIDTH-1:0]     marReg;
    logic [WIDTH-1:0]     linkReg;
    logic [CNT_WIDTH-1:0] updCount;
    logic [WIDTH-1:0]     pc_next;
    logic [WIDTH-1:0]     pc_plus1;
    logic                 jalUpdate;
    link_state_t          linkState;
    link_state_t          linkNext;
    logic                 linkWe;

    pc_next_calc #(.WIDTH(WIDTH)) u_next (
        .pc          (pcReg),
        .disp        (bus.disp),
        .jump_target (bus.jump_target),
        .jumpEn      (bus.jumpEn),
        .branchEn    (bus.branchEn),
        .pc_next     (pc_next),
        .pc_plus1    (pc_plus1)
    );

    assign jalUpdate = bus.PCEn & bus.JALEn & bus.jumpEn;

    // Program counter: loads pc_next only when the controller enables it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcReg <= RESET_PC;
        end else if (bus.PCEn) begin
            pcReg <= pc_next;
        end
    end

    // MAR follows either the load/store address or the fetch address.
    always_ff @(posedge clk) begin
        if (reset) begin
            marReg <= RESET_PC;
        end else if (bus.marRegEn) begin
            marReg <= bus.pcToMAREn ? bus.data_addr : pc_next;
        end
    end

    // Return address captured from the pre-jump PC on a JAL update.
    always_ff @(posedge clk) begin
        if (reset) begin
            linkReg <= '0;
        end else if (jalUpdate) begin
            linkReg <= pc_plus1;
        end
    end

    // Saturating count of PC writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            updCount <= '0;
        end else if (bus.PCEn && (updCount != '1)) begin
            updCount <= updCount + CNT_WIDTH'(1);
        end
    end

    // Link sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            linkState <= LINK_IDLE;
        end else begin
            linkState <= linkNext;
        end
    end

    // Link sequencer transitions; link_we comes from state alone so there
    // is no input-to-output path.
    always_comb begin
        linkNext = LINK_IDLE;
        linkWe   = 1'b0;
        case (linkState)
            LINK_IDLE: begin
                if (jalUpdate) linkNext = LINK_PEND;
            end
            LINK_PEND: begin
                linkWe = 1'b1;
                if (jalUpdate) linkNext = LINK_PEND;
            end
            default: begin
                linkNext = LINK_IDLE;
            end
        endcase
    end

    assign bus.pc         = pcReg;
    assign bus.mar        = marReg;
    assign bus.link_addr  = linkReg;
    assign bus.link_we    = linkWe;
    assign bus.pc_updates = updCount;

endmodule

// File: tb/tb_pc_mar_unit.sv
// Self-checking bench for pc_mar_unit: directed scenarios plus random
// stimulus, checked against an arithmetic reference model.
module tb_pc_mar_unit;

    logic clk;
    logic reset;
    logic reset4;

    int checks   = 0;
    int failures = 0;

    int mPc, mMar, mLink, mCnt;
    bit mLinkWe;

    pc_mar_unit_if #(.WIDTH(16), .CNT_WIDTH(16)) b ();
    pc_mar_unit_if #(.WIDTH(16), .CNT_WIDTH(4))  b4 ();

    pc_mar_unit #(.WIDTH(16), .RESET_PC(16'h0000), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    pc_mar_unit #(.WIDTH(16), .RESET_PC(16'h0000), .CNT_WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset4),
        .bus   (b4)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, advance the model, then sample #1 after the edge.
    task automatic applyStimulus(input logic rst, input logic pce, input logic jmp,
                                 input logic br, input logic jal, input logic mre,
                                 input logic p2m, input logic [7:0] d,
                                 input logic [15:0] jt, input logic [15:0] da);
        int dispVal;
        int nextPc;
        reset         = rst;
        b.PCEn        = pce;
        b.jumpEn      = jmp;
        b.branchEn    = br;
        b.JALEn       = jal;
        b.marRegEn    = mre;
        b.pcToMAREn   = p2m;
        b.disp        = d;
        b.jump_target = jt;
        b.data_addr   = da;
        dispVal = d[7] ? int'(d) - 256 : int'(d);
        if (jmp)     nextPc = int'(jt);
        else if (br) nextPc = (mPc + dispVal + 65536) % 65536;
        else         nextPc = (mPc + 1) % 65536;
        if (rst) begin
            mPc = 0; mMar = 0; mLink = 0; mLinkWe = 0; mCnt = 0;
        end else begin
            mLinkWe = pce && jal && jmp;
            if (mLinkWe) mLink = (mPc + 1) % 65536;
            if (mre) mMar = p2m ? int'(da) : nextPc;
            if (pce) begin
                mPc = nextPc;
                if (mCnt < 65535) mCnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0000);
        applyStimulus(1, 1, 1, 0, 1, 1, 0, 8'h00, 16'h5555, 16'h0000);
        checks++;
        if (b.pc !== 16'h0000 || b.mar !== 16'h0000 || b.link_addr !== 16'h0000 ||
            b.link_we !== 1'b0 || b.pc_updates !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset: pc=%h mar=%h link=%h we=%b cnt=%h required all zero",
                     b.pc, b.mar, b.link_addr, b.link_we, b.pc_updates);
        end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 1, 0, 8'h00, 16'h0000, 16'h0000);
            checks++;
            if (b.pc !== 16'(i) || b.mar !== 16'(i) || b.pc_updates !== 16'(i) ||
                b.link_we !== 1'b0) begin
                failures++;
                $display("[TB] FAIL seq%0d: pc=%h mar=%h cnt=%0d we=%b required pc=mar=cnt=%0d we=0",
                         i, b.pc, b.mar, b.pc_updates, b.link_we, i);
            end
        end
    endtask

    task automatic test_branch();
        applyStimulus(0, 1, 1, 0, 0, 1, 0, 8'h00, 16'h0010, 16'h0000);
        applyStimulus(0, 1, 0, 1, 0, 1, 0, 8'hF0, 16'h0000, 16'h0000);
        checks++;
        if (b.pc !== 16'h0000 || b.mar !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL branch_neg: pc=%h mar=%h required 0000", b.pc, b.mar);
        end
        applyStimulus(0, 1, 1, 0, 0, 1, 0, 8'h00, 16'hFFF0, 16'h0000);
        applyStimulus(0, 1, 0, 1, 0, 1, 0, 8'h7F, 16'h0000, 16'h0000);
        checks++;
        if (b.pc !== 16'h006F || b.mar !== 16'h006F) begin
            failures++;
            $display("[TB] FAIL branch_wrap: pc=%h mar=%h required 006F", b.pc, b.mar);
        end
    endtask

    task automatic test_jal();
        applyStimulus(0, 1, 1, 0, 0, 1, 0, 8'h00, 16'h0020, 16'h0000);
        applyStimulus(0, 1, 1, 0, 1, 1, 0, 8'h00, 16'h0400, 16'h0000);
        checks++;
        if (b.pc !== 16'h0400 || b.mar !== 16'h0400 || b.link_addr !== 16'h0021 ||
            b.link_we !== 1'b1) begin
            failures++;
            $display("[TB] FAIL jal: pc=%h mar=%h link=%h we=%b required 0400 0400 0021 1",
                     b.pc, b.mar, b.link_addr, b.link_we);
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 8'h00, 16'h0000, 16'h0000);
        checks++;
        if (b.link_we !== 1'b0 || b.link_addr !== 16'h0021 || b.pc !== 16'h0400) begin
            failures++;
            $display("[TB] FAIL jal_pulse_end: we=%b link=%h pc=%h required 0 0021 0400",
                     b.link_we, b.link_addr, b.pc);
        end
        applyStimulus(0, 1, 1, 0, 1, 0, 0, 8'h00, 16'h0800, 16'h0000);
        applyStimulus(0, 1, 1, 0, 1, 0, 0, 8'h00, 16'h0900, 16'h0000);
        checks++;
        if (b.link_we !== 1'b1 || b.link_addr !== 16'h0801 || b.pc !== 16'h0900) begin
            failures++;
            $display("[TB] FAIL jal_back_to_back: we=%b link=%h pc=%h required 1 0801 0900",
                     b.link_we, b.link_addr, b.pc);
        end
    endtask

    task automatic test_mar_load();
        logic [15:0] pcBefore;
        pcBefore = b.pc;
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 8'h00, 16'h0000, 16'hBEEF);
        checks++;
        if (b.mar !== 16'hBEEF || b.pc !== 16'(mPc) || b.link_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mar_load: mar=%h pc=%h we=%b required BEEF %h 0",
                     b.mar, b.pc, b.link_we, mPc);
        end
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 8'h33, 16'h7777, 16'h0000);
        checks++;
        if (b.pc !== pcBefore || b.mar !== 16'hBEEF) begin
            failures++;
            $display("[TB] FAIL pc_hold: pc=%h mar=%h required %h BEEF", b.pc, b.mar, pcBefore);
        end
    endtask

    task automatic test_priority();
        applyStimulus(0, 1, 1, 1, 0, 0, 0, 8'h05, 16'h1234, 16'h0000);
        checks++;
        if (b.pc !== 16'h1234) begin
            failures++;
            $display("[TB] FAIL jump_priority: pc=%h required 1234", b.pc);
        end
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 8'h00, 16'hFFFF, 16'h0000);
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 8'h00, 16'h0000, 16'h0000);
        checks++;
        if (b.pc !== 16'h0000 || b.mar !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL incr_wrap: pc=%h mar=%h required 0000", b.pc, b.mar);
        end
    endtask

    task automatic test_reset_override();
        applyStimulus(0, 1, 1, 0, 0, 1, 0, 8'h00, 16'h0ABC, 16'h0000);
        applyStimulus(1, 1, 1, 0, 1, 1, 0, 8'h00, 16'h0400, 16'h0000);
        checks++;
        if (b.pc !== 16'h0000 || b.mar !== 16'h0000 || b.link_addr !== 16'h0000 ||
            b.link_we !== 1'b0 || b.pc_updates !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_jal: pc=%h mar=%h link=%h we=%b cnt=%h required all zero",
                     b.pc, b.mar, b.link_addr, b.link_we, b.pc_updates);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 31) == 0, 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          8'($urandom), 16'($urandom), 16'($urandom));
            checks++;
            if (b.pc !== 16'(mPc) || b.mar !== 16'(mMar) || b.link_addr !== 16'(mLink) ||
                b.link_we !== mLinkWe || b.pc_updates !== 16'(mCnt)) begin
                failures++;
                $display("[TB] FAIL random%0d: pc=%h mar=%h link=%h we=%b cnt=%0d required %h %h %h %b %0d",
                         i, b.pc, b.mar, b.link_addr, b.link_we, b.pc_updates,
                         16'(mPc), 16'(mMar), 16'(mLink), mLinkWe, mCnt);
            end
        end
    endtask

    task automatic test_saturation();
        reset4 = 1'b1;
        @(posedge clk);
        #1;
        reset4  = 1'b0;
        b4.PCEn = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (b4.pc_updates !== 4'((n > 15) ? 15 : n) || b4.pc !== 16'(n)) begin
                failures++;
                $display("[TB] FAIL saturate%0d: cnt=%h pc=%h required %h %h",
                         n, b4.pc_updates, b4.pc, 4'((n > 15) ? 15 : n), 16'(n));
            end
        end
        b4.PCEn = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (b4.pc_updates !== 4'hF || b4.pc !== 16'd20) begin
            failures++;
            $display("[TB] FAIL saturate_hold: cnt=%h pc=%h required F 0014",
                     b4.pc_updates, b4.pc);
        end
    endtask

    // Scenario sequence.
    initial begin
        reset = 1'b1;
        reset4 = 1'b1;
        b.PCEn = 0; b.jumpEn = 0; b.branchEn = 0; b.JALEn = 0;
        b.marRegEn = 0; b.pcToMAREn = 0; b.disp = '0; b.jump_target = '0; b.data_addr = '0;
        b4.PCEn = 0; b4.jumpEn = 0; b4.branchEn = 0; b4.JALEn = 0;
        b4.marRegEn = 0; b4.pcToMAREn = 0; b4.disp = '0; b4.jump_target = '0; b4.data_addr = '0;
        mPc = 0; mMar = 0; mLink = 0; mLinkWe = 0; mCnt = 0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_branch();
        test_jal();
        test_mar_load();
        test_priority();
        test_reset_override();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
